// File: rtl/ham_pkg.sv
// -----------------------------------------------------------------------------
// ham_pkg
// Shared constants for the Hamming coder family (data and codeword widths)
// plus a constant-foldable ceil(log2) helper for sizing pointers and counters.
// No ports; imported by ham_tag_fifo and ham_coder_arb.
// -----------------------------------------------------------------------------
package ham_pkg;

  localparam int HAM_DW = 16;  // data word width
  localparam int HAM_CW = 21;  // codeword width (16 data + 5 check bits)

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ham_tag_fifo.sv
// -----------------------------------------------------------------------------
// ham_tag_fifo
// Small synchronous FIFO holding the requester ID of every word issued to the
// coder, so returned codewords can be steered back in issue order.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   push_i, din_i      write a tag (ignored when full)
//   pop_i              drop the head tag (ignored when empty)
//   dout_o             tag at the read pointer (head)
//   full_o, empty_o    occupancy flags
//   cnt_o              number of stored tags (0..DEPTH)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ham_tag_fifo
  import ham_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CNTW = clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [W-1:0]    din_i,
  input  logic            pop_i,
  output logic [W-1:0]    dout_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CNTW-1:0] cnt_o
);

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   rd;
  logic [AW-1:0]   wr;
  logic [CNTW-1:0] cnt;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (cnt == CNTW'(DEPTH));
  assign empty_o = (cnt == {CNTW{1'b0}});
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem[rd];
  assign cnt_o   = cnt;

  // Storage, pointers and occupancy; pointers wrap modulo DEPTH by width.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd  <= {AW{1'b0}};
      wr  <= {AW{1'b0}};
      cnt <= {CNTW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {W{1'b0}};
      end
    end else begin
      if (do_push) begin
        mem[wr] <= din_i;
        wr      <= wr + AW'(1);
      end
      if (do_pop) begin
        rd <= rd + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: cnt <= cnt;  // idle, or push and pop cancel out
      endcase
    end
  end

endmodule

// File: rtl/ham_coder_arb.sv
// -----------------------------------------------------------------------------
// ham_coder_arb
// Round-robin arbiter sharing one in-order Hamming coder between N requesters.
// The granted word goes to the coder through a registered stage; the winner's
// ID is queued in a tag FIFO and used to steer each returned codeword back.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_dat_i/req_vld_i/req_rdy_o     N requester ports (word k at [k*DW +: DW])
//   cod_dat_o/cod_vld_o/cod_rdy_i     data towards the coder (registered)
//   cod_dat_i/cod_vld_i/cod_rdy_o     codewords back from the coder
//   rsp_dat_o/rsp_vld_o/rsp_rdy_i     shared response bus, one-hot valid
//   inflight_o                        words issued and not yet returned
//   err_o                             sticky: codeword seen with no tag queued
// -----------------------------------------------------------------------------
module ham_coder_arb
  import ham_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = HAM_DW,
  parameter int CW    = HAM_CW,
  parameter int DEPTH = 4,
  localparam int IW   = (N > 1) ? clog2(N) : 1,
  localparam int CNTW = clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N*DW-1:0] req_dat_i,
  input  logic [N-1:0]    req_vld_i,
  output logic [N-1:0]    req_rdy_o,
  output logic [DW-1:0]   cod_dat_o,
  output logic            cod_vld_o,
  input  logic            cod_rdy_i,
  input  logic [CW-1:0]   cod_dat_i,
  input  logic            cod_vld_i,
  output logic            cod_rdy_o,
  output logic [CW-1:0]   rsp_dat_o,
  output logic [N-1:0]    rsp_vld_o,
  input  logic [N-1:0]    rsp_rdy_i,
  output logic [CNTW-1:0] inflight_o,
  output logic            err_o
);

  logic [DW-1:0]   words [N];
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   head;
  logic            any_req;
  logic            can_issue;
  logic            issue;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] cnt;

  // First requester with a valid word, scanning from start upward modulo N.
  function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] start,
                                            input logic [N-1:0]  vld);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    int            s;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = int'(start) + i;
      if (s >= N) begin
        s = s - N;
      end else begin
        s = s;
      end
      idx = IW'(s);
      if (!found && vld[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] r;
    r      = {N{1'b0}};
    r[idx] = 1'b1;
    return r;
  endfunction

  for (genvar k = 0; k < N; k++) begin : g_words
    assign words[k] = req_dat_i[k*DW +: DW];
  end

  assign any_req = |req_vld_i;
  assign grant   = rr_pick(ptr, req_vld_i);
  // The output stage frees up when empty or being taken this cycle; a full tag
  // FIFO blocks issue even if a pop happens in the same cycle.
  assign can_issue = (!cod_vld_o || cod_rdy_i) && !fifo_full;
  assign issue     = |req_rdy_o;
  assign pop       = cod_vld_i && cod_rdy_o;
  assign rsp_dat_o = cod_dat_i;
  assign inflight_o = cnt;

  // Grant handshake and return-path steering (all handshakes off in reset).
  always_comb begin
    req_rdy_o = {N{1'b0}};
    rsp_vld_o = {N{1'b0}};
    cod_rdy_o = 1'b0;
    if (!rst_i && can_issue && any_req) begin
      req_rdy_o = onehot(grant);
    end else begin
      req_rdy_o = {N{1'b0}};
    end
    // An orphan codeword (no tag queued) is neither accepted nor forwarded.
    if (!rst_i && !fifo_empty) begin
      cod_rdy_o = rsp_rdy_i[head];
      if (cod_vld_i) begin
        rsp_vld_o = onehot(head);
      end else begin
        rsp_vld_o = {N{1'b0}};
      end
    end else begin
      cod_rdy_o = 1'b0;
    end
  end

  // Issue register, round-robin pointer and sticky orphan flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr       <= {IW{1'b0}};
      cod_dat_o <= {DW{1'b0}};
      cod_vld_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      if (issue) begin
        cod_dat_o <= words[grant];
        cod_vld_o <= 1'b1;
        ptr       <= (grant == IW'(N - 1)) ? {IW{1'b0}} : grant + IW'(1);
      end else if (cod_rdy_i) begin
        cod_vld_o <= 1'b0;
      end else begin
        cod_vld_o <= cod_vld_o;  // stalled: hold word and valid
      end
      if (cod_vld_i && fifo_empty) begin
        err_o <= 1'b1;
      end else begin
        err_o <= err_o;
      end
    end
  end

  ham_tag_fifo #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_tags (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (issue),
    .din_i   (grant),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (cnt)
  );

endmodule

// File: tb/tb_ham_coder_arb.sv
// -----------------------------------------------------------------------------
// tb_ham_coder_arb
// Directed bench for ham_coder_arb (N=4, DEPTH=4). A queue stands in for the
// coder: words are captured when the DUT hands them over and returned on
// request as a simple tagged code of the data.
// -----------------------------------------------------------------------------
module tb_ham_coder_arb;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int CW    = 21;
  localparam int DEPTH = 4;
  localparam int CNTW  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] req_dat;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_rdy;
  logic [DW-1:0]   cod_dat_o;
  logic            cod_vld_o;
  logic            cod_rdy_i;
  logic [CW-1:0]   cod_dat_i;
  logic            cod_vld_i;
  logic            cod_rdy_o;
  logic [CW-1:0]   rsp_dat;
  logic [N-1:0]    rsp_vld;
  logic [N-1:0]    rsp_rdy;
  logic [CNTW-1:0] inflight;
  logic            err;

  logic [DW-1:0] cq [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ham_coder_arb #(.N(N), .DW(DW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_dat_i  (req_dat),
    .req_vld_i  (req_vld),
    .req_rdy_o  (req_rdy),
    .cod_dat_o  (cod_dat_o),
    .cod_vld_o  (cod_vld_o),
    .cod_rdy_i  (cod_rdy_i),
    .cod_dat_i  (cod_dat_i),
    .cod_vld_i  (cod_vld_i),
    .cod_rdy_o  (cod_rdy_o),
    .rsp_dat_o  (rsp_dat),
    .rsp_vld_o  (rsp_vld),
    .rsp_rdy_i  (rsp_rdy),
    .inflight_o (inflight),
    .err_o      (err)
  );

  function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
    return {5'b10101, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Record coder-side transfers just before the edge, then advance one cycle.
  task automatic tick();
    #1;
    if (cod_vld_i && cod_rdy_o && cq.size() > 0) void'(cq.pop_front());
    if (cod_vld_o && cod_rdy_i) cq.push_back(cod_dat_o);
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [DW-1:0] w);
    req_dat[k*DW +: DW] = w;
  endtask

  // Return the oldest coder word; it must be exp_word and go to exp_vld.
  task automatic ret(input string tag, input logic [N-1:0] exp_vld, input logic [DW-1:0] exp_word);
    logic [DW-1:0] d;
    check({tag, "_coder_has_word"}, 32'(cq.size() != 0), 32'd1);
    if (cq.size() != 0) begin
      d = cq[0];
      check({tag, "_word"}, 32'(d), 32'(exp_word));
      cod_vld_i = 1'b1;
      cod_dat_i = enc(d);
      settle();
      check({tag, "_rsp_vld"}, 32'(rsp_vld), 32'(exp_vld));
      check({tag, "_rsp_dat"}, 32'(rsp_dat), 32'(enc(exp_word)));
      check({tag, "_cod_rdy"}, 32'(cod_rdy_o), 32'd1);
      tick();
      cod_vld_i = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_dat   = {(N*DW){1'b0}};
    req_vld   = 4'b0000;
    cod_rdy_i = 1'b1;
    cod_dat_i = {CW{1'b0}};
    cod_vld_i = 1'b0;
    rsp_rdy   = 4'b1111;

    // Reset state
    tick();
    tick();
    check("rst_cod_vld", 32'(cod_vld_o), 32'd0);
    check("rst_cod_dat", 32'(cod_dat_o), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    check("rst_cod_rdy", 32'(cod_rdy_o), 32'd0);
    rst = 1'b0;
    settle();

    // Single requester 2
    set_word(2, 16'h1234);
    req_vld = 4'b0100;
    settle();
    check("t1_req_rdy", 32'(req_rdy), 32'h4);
    tick();
    req_vld = 4'b0000;
    settle();
    check("t1_cod_dat", 32'(cod_dat_o), 32'h1234);
    check("t1_cod_vld", 32'(cod_vld_o), 32'd1);
    check("t1_inflight1", 32'(inflight), 32'd1);
    tick();
    check("t1_cod_vld_drop", 32'(cod_vld_o), 32'd0);
    tick();
    ret("t1_ret", 4'b0100, 16'h1234);
    settle();
    check("t1_inflight0", 32'(inflight), 32'd0);

    // All four continuously valid from a fresh pointer; coder never returns
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cq.delete();
    for (int k = 0; k < N; k++) set_word(k, 16'hA000 + 16'(k));
    req_vld = 4'b1111;
    for (int k = 0; k < N; k++) begin
      settle();
      check($sformatf("t2_grant%0d", k), 32'(req_rdy), 32'd1 << k);
      tick();
      check($sformatf("t2_cod_dat%0d", k), 32'(cod_dat_o), 32'hA000 + 32'(k));
      check($sformatf("t2_cod_vld%0d", k), 32'(cod_vld_o), 32'd1);
    end
    settle();
    check("t2_full_inflight", 32'(inflight), 32'd4);
    check("t2_full_req_rdy", 32'(req_rdy), 32'd0);
    // Return one while full: no same-cycle bypass
    check("t2_first_word", 32'(cq[0]), 32'hA000);
    cod_vld_i = 1'b1;
    cod_dat_i = enc(cq[0]);
    settle();
    check("t2_ret0_rsp_vld", 32'(rsp_vld), 32'h1);
    check("t2_nobypass", 32'(req_rdy), 32'd0);
    tick();
    cod_vld_i = 1'b0;
    settle();
    check("t2_inflight3", 32'(inflight), 32'd3);
    check("t2_cod_vld_idle", 32'(cod_vld_o), 32'd0);
    check("t2_reissue_rdy", 32'(req_rdy), 32'h1);
    req_vld = 4'b0000;
    ret("t2_ret1", 4'b0010, 16'hA001);
    ret("t2_ret2", 4'b0100, 16'hA002);
    ret("t2_ret3", 4'b1000, 16'hA003);
    settle();
    check("t2_inflight0", 32'(inflight), 32'd0);

    // Coder stall on the issue side
    set_word(0, 16'h00FF);
    req_vld   = 4'b0001;
    cod_rdy_i = 1'b0;
    settle();
    check("t3_req_rdy", 32'(req_rdy), 32'h1);
    tick();
    for (int c = 0; c < 5; c++) begin
      settle();
      check($sformatf("t3_hold_dat%0d", c), 32'(cod_dat_o), 32'h00FF);
      check($sformatf("t3_hold_vld%0d", c), 32'(cod_vld_o), 32'd1);
      check($sformatf("t3_hold_rdy%0d", c), 32'(req_rdy), 32'd0);
      tick();
    end
    cod_rdy_i = 1'b1;
    set_word(0, 16'h0100);
    settle();
    check("t3_resume_rdy", 32'(req_rdy), 32'h1);
    tick();
    req_vld = 4'b0000;
    settle();
    check("t3_next_dat", 32'(cod_dat_o), 32'h0100);
    check("t3_inflight2", 32'(inflight), 32'd2);
    tick();
    ret("t3_ret0", 4'b0001, 16'h00FF);
    ret("t3_ret1", 4'b0001, 16'h0100);

    // Response backpressure on requester 2, then an orphan codeword
    set_word(2, 16'h5555);
    req_vld = 4'b0100;
    tick();
    req_vld = 4'b0000;
    tick();
    rsp_rdy   = 4'b1011;
    cod_vld_i = 1'b1;
    cod_dat_i = enc(16'h5555);
    settle();
    check("t4_bp_rsp_vld", 32'(rsp_vld), 32'h4);
    check("t4_bp_cod_rdy", 32'(cod_rdy_o), 32'd0);
    tick();
    check("t4_bp_inflight", 32'(inflight), 32'd1);
    check("t4_bp_rsp_held", 32'(rsp_vld), 32'h4);
    rsp_rdy = 4'b1111;
    cod_vld_i = 1'b0;
    ret("t4_ret", 4'b0100, 16'h5555);
    settle();
    check("t4_inflight0", 32'(inflight), 32'd0);
    check("t4_err_clear", 32'(err), 32'd0);
    cod_vld_i = 1'b1;
    cod_dat_i = enc(16'hDEAD);
    settle();
    check("t4_orphan_cod_rdy", 32'(cod_rdy_o), 32'd0);
    check("t4_orphan_rsp_vld", 32'(rsp_vld), 32'd0);
    tick();
    cod_vld_i = 1'b0;
    settle();
    check("t4_err_set", 32'(err), 32'd1);
    tick();
    check("t4_err_sticky", 32'(err), 32'd1);

    // Reset with three words in flight
    for (int k = 0; k < N; k++) set_word(k, 16'hA000 + 16'(k));
    req_vld = 4'b1111;
    tick();
    tick();
    tick();
    req_vld = 4'b0000;
    settle();
    check("t5_inflight3", 32'(inflight), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cq.delete();
    settle();
    check("t5_rst_inflight", 32'(inflight), 32'd0);
    check("t5_rst_cod_vld", 32'(cod_vld_o), 32'd0);
    check("t5_rst_err", 32'(err), 32'd0);
    req_vld = 4'b1111;
    settle();
    check("t5_grant0", 32'(req_rdy), 32'h1);
    tick();
    req_vld = 4'b0000;
    settle();
    check("t5_cod_dat", 32'(cod_dat_o), 32'hA000);
    tick();
    ret("t5_ret", 4'b0001, 16'hA000);
    settle();
    check("t5_inflight0", 32'(inflight), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
